// File: rtl/datapath_pkg.sv
// Shared datapath types: register index, one-hot select, select legality check.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package datapath_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int NREG      = 8;

  typedef logic [2:0] reg_idx_t;
  typedef logic [7:0] onehot_sel_t;

  // vld is set only when exactly one select bit is high; idx is then its position
  typedef struct packed {
    logic     vld;
    reg_idx_t idx;
  } onehot_res_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } ack_state_t;

  // Shared legality check so the mux and the control unit agree on what is one-hot
  function automatic onehot_res_t onehot_idx(input onehot_sel_t sel);
    onehot_res_t res;
    int unsigned cnt;
    res = '0;
    cnt = 0;
    for (int i = 0; i < NREG; i++) begin
      if (sel[i]) begin
        cnt++;
        res.idx = reg_idx_t'(i);
      end
    end
    res.vld = (cnt == 1);
    return res;
  endfunction

endpackage

// File: rtl/onehot_decode.sv
// Decodes an 8-bit register select into zero / one-hot flags and a binary index.
// Latency: combinational.
// Backpressure: none; pure decode.
module onehot_decode
  import datapath_pkg::*;
(
  input  logic [NREG-1:0] sel,
  output logic            is_zero,
  output logic            is_onehot,
  output logic [2:0]      idx
);

  onehot_res_t res;

  // Legality and index come from the shared package helper
  always_comb begin
    res       = onehot_idx(sel);
    is_zero   = (sel == '0);
    is_onehot = res.vld;
    idx       = res.idx;
  end

endmodule

// File: rtl/bus_regbank.sv
// Captures the shared bus into one of eight registers on a one-hot select; tracks writes.
// Latency: register and bookkeeping update on the write edge; wr_ack one cycle after it.
// Backpressure: none; every valid one-hot write is accepted, illegal selects are dropped and flagged.
module bus_regbank
  import datapath_pkg::*;
#(
  parameter int WIDTH = datapath_pkg::WIDTH_DEF,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] obus,
  input  logic             bus_valid,
  input  logic [7:0]       Rin_sel,
  input  logic             err_clr,
  output logic [WIDTH-1:0] r0,
  output logic [WIDTH-1:0] r1,
  output logic [WIDTH-1:0] r2,
  output logic [WIDTH-1:0] r3,
  output logic [WIDTH-1:0] r4,
  output logic [WIDTH-1:0] r5,
  output logic [WIDTH-1:0] r6,
  output logic [WIDTH-1:0] r7,
  output logic             wr_ack,
  output logic [2:0]       last_idx,
  output logic [CNT_W-1:0] wr_cnt,
  output logic             sel_err
);

  logic [WIDTH-1:0] regs [NREG];
  logic             sel_zero;
  logic             sel_onehot;
  logic [2:0]       sel_idx;
  logic             wr_accept;
  logic             wr_illegal;
  ack_state_t       state;

  onehot_decode u_dec (
    .sel       (Rin_sel),
    .is_zero   (sel_zero),
    .is_onehot (sel_onehot),
    .idx       (sel_idx)
  );

  // Classify this cycle's bus transfer: accepted write, illegal multi-select, or idle
  always_comb begin
    wr_accept  = bus_valid & sel_onehot;
    wr_illegal = bus_valid & ~sel_zero & ~sel_onehot;
  end

  // Register file plus write bookkeeping; illegal selects touch nothing but the error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      last_idx <= '0;
      wr_cnt   <= '0;
      sel_err  <= 1'b0;
    end else begin
      if (wr_accept) begin
        regs[sel_idx] <= obus;
        last_idx      <= sel_idx;
        wr_cnt        <= wr_cnt + CNT_W'(1);
      end
      // A fresh illegal select outranks a clear in the same cycle
      if (wr_illegal) begin
        sel_err <= 1'b1;
      end else if (err_clr) begin
        sel_err <= 1'b0;
      end
    end
  end

  // Acknowledge FSM: sits in ACK for every cycle that follows an accepted write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: state <= wr_accept ? ST_ACK : ST_IDLE;
        ST_ACK:  state <= wr_accept ? ST_ACK : ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign wr_ack = (state == ST_ACK);

  assign r0 = regs[0];
  assign r1 = regs[1];
  assign r2 = regs[2];
  assign r3 = regs[3];
  assign r4 = regs[4];
  assign r5 = regs[5];
  assign r6 = regs[6];
  assign r7 = regs[7];

endmodule
